// File: rtl/sc_level_tick_gen_pkg.sv
// Shared definitions for the level-driven tick generator: FSM state
// encoding, level width and the top level value.
package sc_level_tick_pkg;

    localparam int LEVEL_W = 2;
    localparam logic [LEVEL_W-1:0] MAX_LEVEL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_LEVELUP = 3'd3,
        ST_SETTLE  = 3'd4
    } state_t;

endpackage

// File: rtl/sc_level_tick_gen_if.sv
// Control/status bundle between the level register side and the tick
// generator. The master drives run/restart/level and watches the pulses.
interface sc_level_tick_gen_if;
    import sc_level_tick_pkg::*;

    logic               SC_LevelTick_run_InLow;
    logic               SC_LevelTick_restart_InLow;
    logic [LEVEL_W-1:0] SC_LevelTick_level_InBUS;
    logic               SC_LevelTick_tick_Out;
    logic               SC_LevelTick_change_level_OutLow;
    logic               SC_LevelTick_max_level_Out;

    modport master (
        output SC_LevelTick_run_InLow,
        output SC_LevelTick_restart_InLow,
        output SC_LevelTick_level_InBUS,
        input  SC_LevelTick_tick_Out,
        input  SC_LevelTick_change_level_OutLow,
        input  SC_LevelTick_max_level_Out
    );

    modport slave (
        input  SC_LevelTick_run_InLow,
        input  SC_LevelTick_restart_InLow,
        input  SC_LevelTick_level_InBUS,
        output SC_LevelTick_tick_Out,
        output SC_LevelTick_change_level_OutLow,
        output SC_LevelTick_max_level_Out
    );

endinterface

// File: rtl/sc_level_tick_gen_prescaler.sv
// Base-unit strobe generator: counts 0..PRESCALE-1 while not held and
// flags the last count. Clear wins over counting and masks the strobe so
// a cleared cycle never produces a base unit.
module sc_prescaler #(
    parameter int PRESCALE  = 50000,
    parameter int CNT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clr,
    output logic strobe
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PRESCALE - 1);

    logic [CNT_WIDTH-1:0] count;

    assign strobe = !hold && !clr && (count == LAST);

    // prescale counter: clear, hold, or count with wrap at LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (!hold) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_level_tick_gen.sv
// Level-driven game-speed timer. Emits a one-cycle tick every
// PRESCALE*PERIOD(level) cycles while running, counts ticks and requests a
// level-up (active-low, one cycle) after TICKS_PER_LEVEL ticks below the
// top level.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | after reset, counters hold until run is first requested
//   RUN     | prescaler/period/tick counters advance
//   PAUSE   | run released; counters hold, no pulses
//   LEVELUP | one cycle; change_level request is registered out
//   SETTLE  | one cycle; level register takes the new level
module sc_level_tick_gen
    import sc_level_tick_pkg::*;
#(
    parameter int PRESCALE        = 50000,
    parameter int PERIOD_L0       = 1000,
    parameter int PERIOD_L1       = 750,
    parameter int PERIOD_L2       = 500,
    parameter int PERIOD_L3       = 250,
    parameter int TICKS_PER_LEVEL = 60,
    parameter int CNT_WIDTH       = 16
) (
    input logic                SC_LevelTick_CLOCK_50,
    input logic                SC_LevelTick_RESET_InLow,
    sc_level_tick_gen_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] P0_LAST   = CNT_WIDTH'(PERIOD_L0 - 1);
    localparam logic [CNT_WIDTH-1:0] P1_LAST   = CNT_WIDTH'(PERIOD_L1 - 1);
    localparam logic [CNT_WIDTH-1:0] P2_LAST   = CNT_WIDTH'(PERIOD_L2 - 1);
    localparam logic [CNT_WIDTH-1:0] P3_LAST   = CNT_WIDTH'(PERIOD_L3 - 1);
    localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(TICKS_PER_LEVEL - 1);

    logic clk;
    logic rst_n;

    state_t state;
    state_t state_next;

    logic [LEVEL_W-1:0]   level;
    logic [LEVEL_W-1:0]   prev_level;
    logic                 run_req;
    logic                 restart;
    logic                 level_changed;
    logic                 cnt_clr;
    logic                 counting;
    logic                 base_strobe;
    logic                 tick_hit;
    logic                 tick_last;
    logic                 levelup_req;
    logic                 change_next;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [CNT_WIDTH-1:0] period_last;
    logic [CNT_WIDTH-1:0] tick_cnt;
    logic                 tick_q;
    logic                 change_q;
    logic                 max_q;

    assign clk   = SC_LevelTick_CLOCK_50;
    assign rst_n = SC_LevelTick_RESET_InLow;

    assign level         = bus.SC_LevelTick_level_InBUS;
    assign run_req       = !bus.SC_LevelTick_run_InLow;
    assign restart       = !bus.SC_LevelTick_restart_InLow;
    assign level_changed = (level != prev_level);
    // any level change, internal or external, starts a clean period
    assign cnt_clr       = restart || level_changed;
    assign counting      = (state == ST_RUN);

    sc_prescaler #(
        .PRESCALE  (PRESCALE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (!counting),
        .clr    (cnt_clr),
        .strobe (base_strobe)
    );

    // period length for the current level
    always_comb begin
        period_last = P0_LAST;
        case (level)
            2'd0:    period_last = P0_LAST;
            2'd1:    period_last = P1_LAST;
            2'd2:    period_last = P2_LAST;
            default: period_last = P3_LAST;
        endcase
    end

    // base_strobe is already masked by clear and hold
    assign tick_hit    = base_strobe && (period_cnt == period_last);
    assign tick_last   = tick_hit && (tick_cnt == TICK_LAST);
    assign levelup_req = tick_last && (level != MAX_LEVEL);

    // period counter: base units within the current tick period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (cnt_clr) begin
            period_cnt <= '0;
        end else if (base_strobe) begin
            if (period_cnt == period_last) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

    // tick counter: ticks since the last level-up boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (cnt_clr) begin
            tick_cnt <= '0;
        end else if (tick_hit) begin
            if (tick_last) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and change-level request
    always_comb begin
        state_next  = state;
        change_next = 1'b1;
        case (state)
            ST_IDLE: begin
                if (run_req) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (levelup_req)   state_next = ST_LEVELUP;
                else if (!run_req) state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (run_req) state_next = ST_RUN;
            end
            ST_LEVELUP: begin
                state_next  = ST_SETTLE;
                change_next = restart;
            end
            ST_SETTLE: begin
                state_next = run_req ? ST_RUN : ST_PAUSE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // restart abandons a level-up in flight
        if (restart && (state == ST_LEVELUP || state == ST_SETTLE)) begin
            state_next = ST_RUN;
        end
    end

    // registered outputs and previous-level tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= 1'b0;
            change_q   <= 1'b1;
            max_q      <= 1'b0;
            prev_level <= '0;
        end else begin
            tick_q     <= tick_hit;
            change_q   <= change_next;
            max_q      <= (level == MAX_LEVEL);
            prev_level <= level;
        end
    end

    assign bus.SC_LevelTick_tick_Out            = tick_q;
    assign bus.SC_LevelTick_change_level_OutLow = change_q;
    assign bus.SC_LevelTick_max_level_Out       = max_q;

endmodule

// File: tb/tb_sc_level_tick_gen.sv
// Scoreboard bench: expected tick and level-up cycles are queued when
// stimulus is applied and popped as the DUT pulses. The bench also plays
// the level register, advancing on each change_level request.
module tb_sc_level_tick_gen;
    import sc_level_tick_pkg::*;

    localparam int PRESCALE = 4;
    localparam int P0 = 4;
    localparam int P1 = 3;
    localparam int P2 = 2;
    localparam int P3 = 1;
    localparam int TPL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sc_level_tick_gen_if ifc();

    sc_level_tick_gen #(
        .PRESCALE        (PRESCALE),
        .PERIOD_L0       (P0),
        .PERIOD_L1       (P1),
        .PERIOD_L2       (P2),
        .PERIOD_L3       (P3),
        .TICKS_PER_LEVEL (TPL),
        .CNT_WIDTH       (16)
    ) dut (
        .SC_LevelTick_CLOCK_50    (clk),
        .SC_LevelTick_RESET_InLow (rst_n),
        .bus                      (ifc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int exp_tick_q[$];
    int exp_req_q[$];
    logic [1:0] level = 2'd0;
    logic [1:0] lvl_sampled = 2'd0;
    bit up_pending = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    task automatic set_level(input logic [1:0] v);
        level = v;
        ifc.SC_LevelTick_level_InBUS = v;
    endtask

    // compare pulses against the scoreboard, then act as the level register
    task automatic monitor();
        if (ifc.SC_LevelTick_tick_Out === 1'b1) begin
            if (exp_tick_q.size() == 0) chk("tick_extra", cyc_n, -1);
            else                        chk("tick_cycle", cyc_n, exp_tick_q.pop_front());
        end else if (exp_tick_q.size() > 0 && exp_tick_q[0] <= cyc_n) begin
            chk("tick_missing", cyc_n, exp_tick_q.pop_front());
        end
        if (ifc.SC_LevelTick_change_level_OutLow === 1'b0) begin
            if (exp_req_q.size() == 0) chk("req_extra", cyc_n, -1);
            else                       chk("req_cycle", cyc_n, exp_req_q.pop_front());
        end else if (exp_req_q.size() > 0 && exp_req_q[0] <= cyc_n) begin
            chk("req_missing", cyc_n, exp_req_q.pop_front());
        end
        chk("max_level", int'(ifc.SC_LevelTick_max_level_Out), int'(lvl_sampled == 2'd3));
        if (up_pending) begin
            up_pending = 1'b0;
            if (level != 2'd3) set_level(level + 2'd1);
        end
        if (ifc.SC_LevelTick_change_level_OutLow === 1'b0) up_pending = 1'b1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc_n++;
            lvl_sampled = level;
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic step_to(input int c);
        while (cyc_n < c) step(1);
    endtask

    // queue n ticks of a level starting from clear edge c; returns next clear edge
    task automatic sched(input int c, input int period, input int n_ticks,
                         input bit req, output int next_c);
        for (int i = 1; i <= n_ticks; i++) exp_tick_q.push_back(c + PRESCALE * period * i);
        if (req) exp_req_q.push_back(c + PRESCALE * period * n_ticks + 1);
        next_c = c + PRESCALE * period * n_ticks + 3;
    endtask

    initial begin
        int c0, c1, c2, c3, unused_c;
        ifc.SC_LevelTick_run_InLow     = 1'b1;
        ifc.SC_LevelTick_restart_InLow = 1'b1;
        set_level(2'd0);
        repeat (3) @(negedge clk);
        chk("rst_tick", int'(ifc.SC_LevelTick_tick_Out), 0);
        chk("rst_req",  int'(ifc.SC_LevelTick_change_level_OutLow), 1);
        chk("rst_max",  int'(ifc.SC_LevelTick_max_level_Out), 0);
        rst_n = 1'b1;

        // paused after reset: no pulses at all
        step(100);

        // level 0 -> 1 -> 2 via three ticks each
        c0 = cyc_n + 1;
        ifc.SC_LevelTick_run_InLow = 1'b0;
        sched(c0, P0, TPL, 1'b1, c1);
        sched(c1, P1, TPL, 1'b1, c2);
        step_to(c2 + 3);
        chk("level_after_ups", int'(level), 2);

        // load level 3: fast ticks, never a request
        set_level(2'd3);
        c3 = cyc_n + 1;
        sched(c3, P3, 10, 1'b0, unused_c);
        step_to(c3 + 42);

        // external clear back to level 0, then a 10-cycle pause mid-period
        set_level(2'd0);
        c0 = cyc_n + 1;
        exp_tick_q.push_back(c0 + 26);
        exp_tick_q.push_back(c0 + 42);
        step_to(c0 + 5);
        ifc.SC_LevelTick_run_InLow = 1'b1;
        step_to(c0 + 15);
        ifc.SC_LevelTick_run_InLow = 1'b0;

        // restart on the edge of the third tick: no tick, no request
        step_to(c0 + 57);
        ifc.SC_LevelTick_restart_InLow = 1'b0;
        step(1);
        ifc.SC_LevelTick_restart_InLow = 1'b1;
        exp_tick_q.push_back(c0 + 74);
        step_to(c0 + 74);

        // async reset while tick is high clears it immediately
        rst_n = 1'b0;
        #1;
        chk("async_rst_tick", int'(ifc.SC_LevelTick_tick_Out), 0);
        chk("async_rst_req",  int'(ifc.SC_LevelTick_change_level_OutLow), 1);
        chk("async_rst_max",  int'(ifc.SC_LevelTick_max_level_Out), 0);

        chk("tick_q_left", exp_tick_q.size(), 0);
        chk("req_q_left",  exp_req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
